// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_if
// Brief    : Decode-side bundle between the decode stage and hazard_scoreboard.
// Revision : 1.0
// ============================================================================
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4,
    parameter int CNT_W  = 16
);
    logic              issue_valid;
    logic              issue_we;
    logic [REG_AW-1:0] issue_rd;
    logic [LAT_W-1:0]  issue_lat;
    logic [REG_AW-1:0] rs_d;
    logic [REG_AW-1:0] rt_d;
    logic              use_rs;
    logic              use_rt;
    logic              kill_d;
    logic              ext_stall;
    logic              stall_f;
    logic              stall_d;
    logic              flush_e;
    logic              busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_lat,
        output rs_d, rt_d, use_rs, use_rt, kill_d, ext_stall,
        input  stall_f, stall_d, flush_e, busy, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_lat,
        input  rs_d, rt_d, use_rs, use_rt, kill_d, ext_stall,
        output stall_f, stall_d, flush_e, busy, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register countdown scoreboard driving fetch/decode stalls and
//            execute bubbles for RAW and WAW hazards, with a stall counter.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  sb
);
    localparam int c_num_regs = 2 ** REG_AW;

    logic [LAT_W-1:0]      w_pend [c_num_regs];
    logic [c_num_regs-1:0] w_nz;
    logic                  w_raw;
    logic                  w_waw;
    logic                  w_haz;
    logic                  w_accept;
    logic                  w_load;
    logic [CNT_W-1:0]      r_stall_cnt;

    // Register 0 is hard-wired zero, so it never holds a pending write.
    assign w_pend[0] = '0;
    assign w_nz[0]   = 1'b0;

    generate
        for (genvar r = 1; r < c_num_regs; r++) begin : g_entry
            logic [LAT_W-1:0] r_pend;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pend <= '0;
                end else if (!sb.ext_stall) begin
                    if (w_load && (sb.issue_rd == REG_AW'(r))) begin
                        r_pend <= sb.issue_lat;
                    end else if (r_pend != '0) begin
                        r_pend <= r_pend - LAT_W'(1);
                    end
                end
            end

            assign w_pend[r] = r_pend;
            assign w_nz[r]   = (r_pend != '0);
        end
    endgenerate

    // Hazards look at pend before this cycle's update, so a self-overwriting
    // instruction waits only for the older writer.
    assign w_raw = sb.issue_valid &
                   ((sb.use_rs & (sb.rs_d != '0) & w_nz[sb.rs_d]) |
                    (sb.use_rt & (sb.rt_d != '0) & w_nz[sb.rt_d]));
    assign w_waw = sb.issue_valid & sb.issue_we & (sb.issue_rd != '0) &
                   (w_pend[sb.issue_rd] > sb.issue_lat);
    assign w_haz    = (w_raw | w_waw) & ~sb.kill_d;
    assign w_accept = sb.issue_valid & ~w_haz & ~sb.ext_stall & ~sb.kill_d;
    assign w_load   = w_accept & sb.issue_we & (sb.issue_rd != '0) &
                      (sb.issue_lat != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_haz && !sb.ext_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign sb.stall_f   = w_haz | sb.ext_stall;
    assign sb.stall_d   = w_haz | sb.ext_stall;
    assign sb.flush_e   = w_haz & ~sb.ext_stall;
    assign sb.busy      = |w_nz;
    assign sb.stall_cnt = r_stall_cnt;
endmodule
`default_nettype wire
